tx_fifo_rptr_sync_w: RTL and testbench

//  Write-domain endpoint of the TX async FIFO read-pointer crossing; complements the write-pointer block.

---
 rtl/tx_fifo_rptr_sync_w_pkg.sv | 15 +
 rtl/tx_fifo_rptr_sync_w_gray_to_binary.sv | 15 +
 rtl/tx_fifo_rptr_sync_w.sv | 66 ++++++
 tb/tb_tx_fifo_rptr_sync_w.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tx_fifo_rptr_sync_w_pkg.sv
// tx_fifo_rptr_sync_w_pkg: shared pointer-width define, synchronizer default and depth helper
//   `TX_POINTER      default FIFO pointer width including the wrap bit
//   TX_POINTER_W     package copy of `TX_POINTER
//   SYNC_STAGES_DEF  default synchronizer depth
//   depth_of(pw)     FIFO depth for a pointer width, 2**(pw-1)
`ifndef TX_POINTER
`define TX_POINTER 4
`endif
package tx_fifo_rptr_sync_w_pkg;
   localparam int TX_POINTER_W    = `TX_POINTER;
   localparam int SYNC_STAGES_DEF = 2;
   function automatic int depth_of(input int pw);
      return 1 << (pw - 1);
   endfunction
endpackage

// File: rtl/tx_fifo_rptr_sync_w_gray_to_binary.sv
// gray_to_binary: combinational gray-to-binary conversion, counterpart of binary_to_gray
//   gray  in   PW  gray-coded value
//   bin   out  PW  binary value; bin[i] is the XOR of gray[PW-1:i]
module gray_to_binary
   import tx_fifo_rptr_sync_w_pkg::*;
#(
   parameter int PW = TX_POINTER_W
) (
   input  logic [PW-1:0] gray,
   output logic [PW-1:0] bin
);
   for (genvar i = 0; i < PW; i++) begin : g_bit
      assign bin[i] = ^gray[PW-1:i];
   end
endmodule

// File: rtl/tx_fifo_rptr_sync_w.sv
// tx_fifo_rptr_sync_w: write-domain read-pointer synchronizer with level, full and overflow flags
//   w_clk            in   1   write-domain clock
//   wrst_n           in   1   asynchronous active-low reset
//   gray_rptr_async  in   PW  gray read pointer from r_clk, unsynchronized
//   gray_wptr        in   PW  gray write pointer, w_clk domain
//   winc             in   1   write attempt this cycle
//   ov_clr           in   1   synchronous clear of woverflow
//   gray_rptr_sync   out  PW  synchronized gray read pointer
//   wfull            out  1   combinational full flag
//   walmost_full     out  1   registered, wlevel >= AFULL_LVL
//   wlevel           out  PW  registered occupancy 0..DEPTH
//   woverflow        out  1   sticky write-while-full flag
module tx_fifo_rptr_sync_w
   import tx_fifo_rptr_sync_w_pkg::*;
#(
   parameter int POINTER_WIDTH = TX_POINTER_W,
   parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
   parameter int AFULL_LVL     = depth_of(POINTER_WIDTH) - 2
) (
   input  logic                     w_clk,
   input  logic                     wrst_n,
   input  logic [POINTER_WIDTH-1:0] gray_rptr_async,
   input  logic [POINTER_WIDTH-1:0] gray_wptr,
   input  logic                     winc,
   input  logic                     ov_clr,
   output logic [POINTER_WIDTH-1:0] gray_rptr_sync,
   output logic                     wfull,
   output logic                     walmost_full,
   output logic [POINTER_WIDTH-1:0] wlevel,
   output logic                     woverflow
);
   localparam int PW = POINTER_WIDTH;
   localparam logic [PW-1:0] AFULL_V = PW'(AFULL_LVL);
   logic [PW-1:0] rbin, wbin, rbin_q, level_next;
   for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
      logic [PW-1:0] d, q;
      if (s == 0) begin : g_first
         assign d = gray_rptr_async;
      end else begin : g_next
         assign d = g_sync[s-1].q;
      end
      always_ff @(posedge w_clk or negedge wrst_n)
         if (!wrst_n) q <= '0;
         else q <= d;
   end
   assign gray_rptr_sync = g_sync[SYNC_STAGES-1].q;
   // gray full pattern: top two bits inverted, remaining bits equal
   assign wfull = (gray_wptr[PW-1:PW-2] == ~gray_rptr_sync[PW-1:PW-2]) &&
                  (gray_wptr[PW-3:0] == gray_rptr_sync[PW-3:0]);
   gray_to_binary #(.PW(PW)) u_rg2b (.gray(gray_rptr_sync), .bin(rbin));
   gray_to_binary #(.PW(PW)) u_wg2b (.gray(gray_wptr), .bin(wbin));
   // modulo subtraction absorbs pointer wrap
   assign level_next = wbin - rbin_q;
   always_ff @(posedge w_clk or negedge wrst_n)
      if (!wrst_n) begin
         rbin_q       <= '0;
         wlevel       <= '0;
         walmost_full <= 1'b0;
         woverflow    <= 1'b0;
      end else begin
         rbin_q       <= rbin;
         wlevel       <= level_next;
         walmost_full <= level_next >= AFULL_V;
         woverflow    <= (winc && wfull) ? 1'b1 : ov_clr ? 1'b0 : woverflow;
      end
endmodule

// File: tb/tb_tx_fifo_rptr_sync_w.sv
// tb_tx_fifo_rptr_sync_w: directed bench for the write-domain read-pointer synchronizer
module tb_tx_fifo_rptr_sync_w;
   logic       w_clk = 1'b0;
   logic       wrst_n = 1'b0;
   logic [3:0] gray_rptr_async = '0;
   logic [3:0] gray_wptr = '0;
   logic       winc = 1'b0;
   logic       ov_clr = 1'b0;
   logic [3:0] gray_rptr_sync;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       woverflow;
   int n_assert = 0;
   int n_fail = 0;

   tx_fifo_rptr_sync_w #(.POINTER_WIDTH(4), .SYNC_STAGES(2), .AFULL_LVL(6)) dut (
      .w_clk(w_clk), .wrst_n(wrst_n), .gray_rptr_async(gray_rptr_async),
      .gray_wptr(gray_wptr), .winc(winc), .ov_clr(ov_clr),
      .gray_rptr_sync(gray_rptr_sync), .wfull(wfull), .walmost_full(walmost_full),
      .wlevel(wlevel), .woverflow(woverflow)
   );

   always #5 w_clk = ~w_clk;

   function automatic logic [3:0] g(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic tick();
      @(posedge w_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tick();
      chk("rst_sync", 8'(gray_rptr_sync), 8'h0);
      chk("rst_full", 8'(wfull), 8'h0);
      chk("rst_afull", 8'(walmost_full), 8'h0);
      chk("rst_level", 8'(wlevel), 8'h0);
      chk("rst_ovf", 8'(woverflow), 8'h0);
      #2 wrst_n = 1'b1;
      // fill: level trails the write pointer by one edge
      for (int k = 1; k <= 8; k++) begin
         gray_wptr = g(k);
         #1;
         chk($sformatf("fill_full_%0d", k), 8'(wfull), (k == 8) ? 8'h1 : 8'h0);
         tick();
         chk($sformatf("fill_level_%0d", k), 8'(wlevel), 8'(k));
         chk($sformatf("fill_afull_%0d", k), 8'(walmost_full), (k >= 6) ? 8'h1 : 8'h0);
      end
      chk("full_code", 8'(gray_wptr), 8'hc);
      // overflow set, hold, clear, set-beats-clear
      winc = 1'b1;
      tick();
      winc = 1'b0;
      chk("ovf_set", 8'(woverflow), 8'h1);
      tick();
      chk("ovf_hold", 8'(woverflow), 8'h1);
      ov_clr = 1'b1;
      tick();
      ov_clr = 1'b0;
      chk("ovf_clr", 8'(woverflow), 8'h0);
      winc = 1'b1;
      ov_clr = 1'b1;
      tick();
      winc = 1'b0;
      chk("ovf_set_wins", 8'(woverflow), 8'h1);
      tick();
      chk("ovf_clr2", 8'(woverflow), 8'h0);
      ov_clr = 1'b0;
      // read drain; overflow raised again on the first edge while still full
      gray_rptr_async = 4'b0001;
      winc = 1'b1;
      tick();
      winc = 1'b0;
      chk("drain_ovf", 8'(woverflow), 8'h1);
      chk("drain_sync1", 8'(gray_rptr_sync), 8'h0);
      chk("drain_full1", 8'(wfull), 8'h1);
      tick();
      chk("drain_sync2", 8'(gray_rptr_sync), 8'h1);
      chk("drain_full2", 8'(wfull), 8'h0);
      chk("drain_level2", 8'(wlevel), 8'h8);
      tick();
      chk("drain_level3", 8'(wlevel), 8'h8);
      tick();
      chk("drain_level4", 8'(wlevel), 8'h7);
      chk("drain_afull4", 8'(walmost_full), 8'h1);
      // wrap: settle at wptr=15, rptr=12, then write wraps to 0 and read advances to 13
      gray_wptr = g(15);
      gray_rptr_async = g(12);
      repeat (5) tick();
      chk("wrap_level_a", 8'(wlevel), 8'h3);
      chk("wrap_full_a", 8'(wfull), 8'h0);
      gray_wptr = g(0);
      gray_rptr_async = g(13);
      tick();
      chk("wrap_level_b", 8'(wlevel), 8'h4);
      chk("wrap_full_b", 8'(wfull), 8'h0);
      tick();
      chk("wrap_level_c", 8'(wlevel), 8'h4);
      chk("wrap_full_c", 8'(wfull), 8'h0);
      tick();
      chk("wrap_level_d", 8'(wlevel), 8'h4);
      tick();
      chk("wrap_level_e", 8'(wlevel), 8'h3);
      chk("wrap_afull_e", 8'(walmost_full), 8'h0);
      chk("wrap_ovf_kept", 8'(woverflow), 8'h1);
      // continue filling to level 5 across the wrap
      gray_wptr = g(1);
      tick();
      chk("refill_level4", 8'(wlevel), 8'h4);
      gray_wptr = g(2);
      tick();
      chk("refill_level5", 8'(wlevel), 8'h5);
      // asynchronous reset between edges
      #2;
      wrst_n = 1'b0;
      gray_wptr = '0;
      #1;
      chk("mid_rst_level", 8'(wlevel), 8'h0);
      chk("mid_rst_sync", 8'(gray_rptr_sync), 8'h0);
      chk("mid_rst_ovf", 8'(woverflow), 8'h0);
      chk("mid_rst_afull", 8'(walmost_full), 8'h0);
      chk("mid_rst_full", 8'(wfull), 8'h0);
      gray_rptr_async = 4'b0011;
      tick();
      chk("in_rst_sync", 8'(gray_rptr_sync), 8'h0);
      @(negedge w_clk);
      wrst_n = 1'b1;
      tick();
      chk("post_rst_sync1", 8'(gray_rptr_sync), 8'h0);
      tick();
      chk("post_rst_sync2", 8'(gray_rptr_sync), 8'h3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
